alu_dispatch: RTL and testbench
===============================

// Module: alu_dispatch
// PURPOSE
//   Upstream issue stage for the Alu block. Buffers incoming ALU operations in a
//   small FIFO (valid/ready), drives opcode/A_in/B_in to Alu one op at a time,
//   holds them stable for the fixed ALU latency, captures Alu_out and presents
//   it downstream with a valid/ready handshake. One op in flight at a time.
// PARAMETERS
//   DATA_WIDTH   1024  operand/result width; matches Alu DATA_WIDTH
//   DEPTH        4     input FIFO entries; power of 2, >= 2
//   ALU_LATENCY  3     cycles from issue edge to Alu_out valid; >= 1
// PORTS
//   clk          in   1           single clock, all logic on posedge
//   rst_n        in   1           asynchronous reset, active-low
//   in_valid     in   1           upstream op valid
//   in_ready     out  1           FIFO can accept (= !full)
//   in_opcode    in   3           0 PARITY, 1 POPCOUNT, 2 ROTR, 3 ROTL
//   in_a         in   DATA_WIDTH  operand A
//   in_b         in   DATA_WIDTH  operand B (rotate magnitude for ROTR/ROTL)
//   alu_opcode   out  3           to Alu opcode; 3'b111 (idle) when nothing issued
//   alu_a        out  DATA_WIDTH  to Alu A_in
//   alu_b        out  DATA_WIDTH  to Alu B_in
//   alu_result   in   DATA_WIDTH  from Alu Alu_out
//   out_valid    out  1           captured result valid
//   out_ready    in   1           downstream accepts result
//   out_result   out  DATA_WIDTH  captured result
//   out_opcode   out  3           opcode of captured result
//   busy         out  1           FIFO non-empty or FSM not IDLE
// BEHAVIOUR
//   Reset (rst_n low, any time): FIFO emptied, FSM -> IDLE, in-flight op discarded;
//     in_ready=0 while rst_n low, 1 from first edge after release; alu_opcode=3'b111;
//     alu_a/alu_b/out_result=0; out_valid=0; out_opcode=0; busy=0.
//   FIFO: push on in_valid&&in_ready; pop when FSM takes head. Occupancy counter
//     0..DEPTH; pointers wrap modulo DEPTH. Full -> in_ready=0 (no push). Push and
//     pop on same edge: occupancy unchanged. Push into empty FIFO: entry visible
//     to FSM next cycle (one-cycle bubble, no bypass).
//   FSM states:
//     IDLE: if FIFO non-empty -> pop head; opcode 0-3 -> load alu_* regs, cnt=0,
//       go HOLD; opcode 4-7 -> dropped (popped, no issue, no result), stay IDLE.
//     HOLD: alu_opcode/alu_a/alu_b stable; cnt increments each edge; on edge with
//       cnt==ALU_LATENCY-1 register alu_result->out_result, opcode->out_opcode,
//       out_valid=1, go WAIT. Issue edge T => capture edge T+ALU_LATENCY.
//     WAIT: alu_opcode held (Alu output mux keeps selecting result). out_result
//       stable while out_valid && !out_ready. On edge with out_ready: out_valid=0;
//       if FIFO non-empty and head opcode 0-3, issue it on that same edge (-> HOLD),
//       else alu_opcode=3'b111 and -> IDLE (invalid head handled in IDLE).
//   Throughput: back-to-back ops with out_ready=1 issue every ALU_LATENCY+1 cycles.
//   in_valid without in_ready: op not taken; upstream must hold it.
// TESTING
//   1. Reset: rst_n=0 mid-HOLD with 2 queued ops -> all outputs reset values,
//      FIFO empty, no out_valid after release.
//   2. POPCOUNT, A=0xF0F0, out_ready=1 -> alu_opcode=1 for 3 cycles, out_valid
//      pulse 1 cycle at issue+3 with out_result=popcount result (8), out_opcode=1.
//   3. ROTL A=1, B=4 then ROTR A=1, B=1 back-to-back -> results 0x10 then
//      1<<(DATA_WIDTH-1), in order, issue edges 4 cycles apart.
//   4. Push 5 ops with out_ready=0 -> in_ready drops after FIFO holds 4 (1 in
//      flight, DEPTH queued); out_result held stable; release out_ready -> all 5 drain.
//   5. Opcode 3'b101 between two PARITY ops -> exactly 2 results, invalid dropped.
//   6. Push and out handshake on same edge at full FIFO -> occupancy unchanged
//      across wrap of write pointer, no lost or duplicated op.

Source files
------------

// File: rtl/alu_dispatch.sv
// Issue stage for the Alu block: buffers ops in a small FIFO, issues one at a time,
// holds operands for the fixed Alu latency and presents the captured result downstream.
module alu_dispatch #(
    parameter int unsigned DATA_WIDTH  = 1024,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ALU_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_opcode,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic [2:0]            alu_opcode,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [2:0]            out_opcode,
    output logic                  busy
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned LW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam logic [2:0] OP_IDLE = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_WAIT
    } state_t;

    logic [2:0]            fifo_op_q [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_a_q  [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_b_q  [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rdy_en_q;

    state_t                state_q;
    logic [LW-1:0]         cnt_q;
    logic [2:0]            alu_op_q;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_b_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_result_q;
    logic [2:0]            out_opcode_q;

    logic       push, pop, issue, head_legal;
    logic [2:0] head_op;

    assign in_ready = rdy_en_q && (count_q != CW'(DEPTH));

    // A WAIT-state pop only happens for a legal head; illegal heads are dropped from IDLE.
    always_comb begin
        push       = in_valid && in_ready;
        head_op    = fifo_op_q[rd_ptr_q];
        head_legal = !head_op[2];
        pop        = (count_q != '0) &&
                     ((state_q == S_IDLE) ||
                      ((state_q == S_WAIT) && out_ready && head_legal));
        issue      = pop && head_legal;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op_q[wr_ptr_q] <= in_opcode;
            fifo_a_q[wr_ptr_q]  <= in_a;
            fifo_b_q[wr_ptr_q]  <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdy_en_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            alu_op_q     <= OP_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_opcode_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (issue) begin
                        alu_op_q <= head_op;
                        alu_a_q  <= fifo_a_q[rd_ptr_q];
                        alu_b_q  <= fifo_b_q[rd_ptr_q];
                        cnt_q    <= '0;
                        state_q  <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    cnt_q <= cnt_q + LW'(1);
                    if (cnt_q == LW'(ALU_LATENCY - 1)) begin
                        out_result_q <= alu_result;
                        out_opcode_q <= alu_op_q;
                        out_valid_q  <= 1'b1;
                        state_q      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (issue) begin
                            alu_op_q <= head_op;
                            alu_a_q  <= fifo_a_q[rd_ptr_q];
                            alu_b_q  <= fifo_b_q[rd_ptr_q];
                            cnt_q    <= '0;
                            state_q  <= S_HOLD;
                        end else begin
                            alu_op_q <= OP_IDLE;
                            state_q  <= S_IDLE;
                        end
                    end
                end
                default: begin
                    alu_op_q <= OP_IDLE;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_opcode = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_opcode = out_opcode_q;
    assign busy       = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: directed vector table, multi-cycle sequences and a
// randomized phase scored against an in-order result queue.
module tb_alu_dispatch;

    localparam int unsigned DW  = 1024;
    localparam int unsigned LAT = 3;

    logic          clk, rst_n;
    logic          in_valid, in_ready;
    logic [2:0]    in_opcode;
    logic [DW-1:0] in_a, in_b;
    logic [2:0]    alu_opcode;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_result;
    logic [2:0]    out_opcode;
    logic          busy;

    alu_dispatch #(.DATA_WIDTH(DW), .DEPTH(4), .ALU_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_a(in_a), .in_b(in_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_opcode(out_opcode), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference Alu behaviour straight from the opcode definitions.
    function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [DW-1:0] r, m;
        int unsigned   s;
        r = '0;
        m = b % DW;
        s = m[31:0];
        case (op)
            3'd0: r[0] = ^a;
            3'd1: r = DW'($countones(a));
            3'd2: for (int unsigned i = 0; i < DW; i++) r[i] = a[(i + s) % DW];
            3'd3: for (int unsigned i = 0; i < DW; i++) r[(i + s) % DW] = a[i];
            default: r = '0;
        endcase
        return r;
    endfunction

    // Pipelined Alu: output reflects inputs applied LAT edges earlier.
    logic [DW-1:0] st0, st1;
    always @(posedge clk) begin
        st0 <= ref_alu(alu_opcode, alu_a, alu_b);
        st1 <= st0;
    end
    assign alu_result = st1;

    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;
    int cyc   = 0;

    typedef struct {
        logic [2:0]    op;
        logic [DW-1:0] res;
    } exp_t;
    exp_t          exp_q[$];
    logic          prev_hold = 1'b0;
    logic [DW-1:0] held_res;

    typedef struct {
        logic [2:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] res;
    } vec_t;
    vec_t vt[10];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h (low 64 bits) @cyc %0d",
                     nm, act[63:0], exp[63:0], cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            prev_hold = 1'b0;
            return;
        end
        if (prev_hold) begin
            chk("held_valid", DW'(out_valid), DW'(1));
            chk("held_result", out_result, held_res);
        end
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got 0x%h with no op pending @cyc %0d",
                         out_result[63:0], cyc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_result", out_result, e.res);
                chk("sb_opcode", DW'(out_opcode), DW'(e.op));
            end
        end
        if (in_valid && in_ready && !in_opcode[2])
            exp_q.push_back('{op: in_opcode, res: ref_alu(in_opcode, in_a, in_b)});
        prev_hold = out_valid && !out_ready;
        held_res  = out_result;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] r;
        for (int i = 0; i < int'(DW / 32); i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, DW'(in_ready), DW'(0));
        chk({tag, "_alu_opcode"}, DW'(alu_opcode), DW'(3'b111));
        chk({tag, "_alu_a"}, alu_a, '0);
        chk({tag, "_alu_b"}, alu_b, '0);
        chk({tag, "_out_valid"}, DW'(out_valid), DW'(0));
        chk({tag, "_out_result"}, out_result, '0);
        chk({tag, "_out_opcode"}, DW'(out_opcode), DW'(0));
        chk({tag, "_busy"}, DW'(busy), DW'(0));
    endtask

    task automatic push_op(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int w;
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        if (!in_ready) chk("push_timeout", DW'(in_ready), DW'(1));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < budget && (busy || out_valid); i++) tick();
        chk("drain_busy", DW'(busy), DW'(0));
        chk("drain_pending", DW'(exp_q.size()), DW'(0));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string s;
        s = $sformatf("vec%0d", idx);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_opcode = v.op;
        in_a      = v.a;
        in_b      = v.b;
        tick();
        in_valid = 1'b0;
        chk({s, "_bubble"}, DW'(alu_opcode), DW'(3'b111));
        tick();
        chk({s, "_issue_op"}, DW'(alu_opcode), DW'(v.op));
        for (int k = 1; k <= int'(LAT); k++) begin
            tick();
            if (k < int'(LAT)) begin
                chk({s, "_early_valid"}, DW'(out_valid), DW'(0));
                chk({s, "_hold_op"}, DW'(alu_opcode), DW'(v.op));
            end
        end
        chk({s, "_cap_valid"}, DW'(out_valid), DW'(1));
        chk({s, "_result"}, out_result, v.res);
        chk({s, "_opcode"}, DW'(out_opcode), DW'(v.op));
        tick();
        chk({s, "_pulse_end"}, DW'(out_valid), DW'(0));
        chk({s, "_idle_op"}, DW'(alu_opcode), DW'(3'b111));
        drain(20);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] msb, r0, r1;
        int t1, t2, n0, nres, w;
        logic saw_full;

        msb = '0;
        msb[DW-1] = 1'b1;
        vt[0] = '{3'd1, DW'(32'hF0F0), '0,          DW'(8)};
        vt[1] = '{3'd0, DW'(7),        '0,          DW'(1)};
        vt[2] = '{3'd0, DW'(3),        '0,          DW'(0)};
        vt[3] = '{3'd3, DW'(1),        DW'(4),      DW'(32'h10)};
        vt[4] = '{3'd2, DW'(1),        DW'(1),      msb};
        vt[5] = '{3'd2, DW'(32'h10),   DW'(4),      DW'(1)};
        vt[6] = '{3'd3, DW'(1),        DW'(1024),   DW'(1)};
        vt[7] = '{3'd3, DW'(3),        DW'(1025),   DW'(6)};
        vt[8] = '{3'd1, '1,            '0,          DW'(1024)};
        vt[9] = '{3'd2, msb,           DW'(1023),   DW'(1)};

        rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
        tick();
        tick();
        chk_reset_vals("por");
        rst_n = 1'b1;
        chk("release_in_ready_low", DW'(in_ready), DW'(0));
        tick();
        chk("release_in_ready_high", DW'(in_ready), DW'(1));

        for (int i = 0; i < 10; i++) run_vec(vt[i], i);

        // Back-to-back rotates: issue edges LAT+1 apart, results in order.
        out_ready = 1'b1;
        t1 = -1; t2 = -1; nres = 0; r0 = '0; r1 = '0;
        in_valid = 1'b1; in_opcode = 3'd3; in_a = DW'(1); in_b = DW'(4);
        tick();
        if (alu_opcode == 3'd3 && t1 < 0) t1 = cyc;
        in_opcode = 3'd2; in_a = DW'(1); in_b = DW'(1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (alu_opcode == 3'd3 && t1 < 0) t1 = cyc;
            if (alu_opcode == 3'd2 && t2 < 0) t2 = cyc;
            if (out_valid) begin
                if (nres == 0) r0 = out_result; else r1 = out_result;
                nres++;
            end
            tick();
        end
        chk("b2b_spacing", DW'(t2 - t1), DW'(LAT + 1));
        chk("b2b_count", DW'(nres), DW'(2));
        chk("b2b_first", r0, DW'(32'h10));
        chk("b2b_second", r1, msb);
        drain(20);

        // Illegal opcode between two parity ops is dropped.
        n0 = n_out;
        push_op(3'd0, DW'(7), '0);
        push_op(3'b101, rnd_word(), rnd_word());
        push_op(3'd0, DW'(3), '0);
        drain(40);
        chk("drop_count", DW'(n_out - n0), DW'(2));

        // Backpressure: one in flight plus DEPTH queued, then in_ready drops.
        n0 = n_out;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_opcode = 3'(i % 4); in_a = DW'(i + 1); in_b = DW'(1);
            chk("bp_ready", DW'(in_ready), DW'(1));
            tick();
        end
        in_opcode = 3'd1; in_a = DW'(32'hFF);
        for (int i = 0; i < 10; i++) begin
            chk("bp_full", DW'(in_ready), DW'(0));
            tick();
        end
        in_valid = 1'b0;
        chk("bp_held_valid", DW'(out_valid), DW'(1));
        drain(80);
        chk("bp_drained", DW'(n_out - n0), DW'(5));

        // Continuous stream at full FIFO wraps the pointers several times.
        n0 = n_out;
        saw_full = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_opcode = 3'(i % 4); in_a = rnd_word(); in_b = DW'(i);
            w = 0;
            while (!in_ready && w < 50) begin
                saw_full = 1'b1;
                tick();
                w++;
            end
            chk("stream_accept", DW'(in_ready), DW'(1));
            tick();
        end
        in_valid = 1'b0;
        drain(100);
        chk("stream_full_seen", DW'(saw_full), DW'(1));
        chk("stream_count", DW'(n_out - n0), DW'(12));

        // Asynchronous reset mid-HOLD with two ops queued.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_opcode = 3'd1; in_a = rnd_word(); in_b = '0;
            tick();
        end
        in_valid = 1'b0;
        chk("rst_pre_busy", DW'(busy), DW'(1));
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst");
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post_rst_valid", DW'(out_valid), DW'(0));
            chk("post_rst_busy", DW'(busy), DW'(0));
        end
        chk("post_rst_outputs", DW'(n_out - n0), DW'(0));

        // Randomized traffic with random downstream backpressure.
        in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic acc;
            if (!in_valid && $urandom_range(0, 9) < 7) begin
                in_valid  = 1'b1;
                in_opcode = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3))
                                                       : 3'($urandom_range(4, 7));
                in_a      = rnd_word();
                in_b      = $urandom_range(0, 1) ? DW'($urandom_range(0, 2047)) : rnd_word();
            end
            out_ready = 1'($urandom_range(0, 1));
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
        end
        drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
